// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: function codes, FSM states, captured request.
// No logic; constants and types only.
// No flow control of its own.
package alu_arbiter_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        FN_NOP = 3'd0,
        FN_ADD = 3'd1,
        FN_SUB = 3'd2,
        FN_AND = 3'd3,
        FN_OR  = 3'd4,
        FN_XOR = 3'd5
    } func_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [2:0]        func;
        logic              id;
    } req_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU with zero/sign/signed-overflow flags.
// Latency: zero cycles.
// Backpressure: none, purely combinational.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [2:0]        func,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              sign,
    output logic              ovf
);

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (func)
            FN_ADD: begin
                result = op1 + op2;
                ovf    = (op1[DATA_W-1] == op2[DATA_W-1]) && (result[DATA_W-1] != op1[DATA_W-1]);
            end
            FN_SUB: begin
                result = op1 - op2;
                ovf    = (op1[DATA_W-1] != op2[DATA_W-1]) && (result[DATA_W-1] != op1[DATA_W-1]);
            end
            FN_AND:  result = op1 & op2;
            FN_OR:   result = op1 | op2;
            FN_XOR:  result = op1 ^ op2;
            default: ;  // unused codes yield a clean zero result
        endcase
    end

    assign zero = (result == '0);
    assign sign = result[DATA_W-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters (IDLE -> EXEC -> RESP).
// Latency: rsp valid two cycles after the handshake; one operation per three cycles.
// Backpressure: ready is offered only in IDLE to a single winner; responses cannot be stalled.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [2:0]        req0_func,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [2:0]        req1_func,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_sign,
    output logic              rsp_ovf,
    output logic              busy
);

    state_t            state;
    req_t              cap;
    logic              last_gnt;
    logic              gnt_id;
    logic              take;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_sign;
    logic              alu_ovf;

    // Contention goes to whoever was not served last; a lone requester always wins.
    assign gnt_id     = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
    assign take       = (state == ST_IDLE) && !reset && (req0_valid || req1_valid);
    assign req0_ready = take && !gnt_id;
    assign req1_ready = take && gnt_id;
    assign busy       = (state != ST_IDLE);

    alu_arbiter_alu u_alu (
        .op1    (cap.op1),
        .op2    (cap.op2),
        .func   (cap.func),
        .result (alu_result),
        .zero   (alu_zero),
        .sign   (alu_sign),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cap        <= '0;
            last_gnt   <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_sign   <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        cap.op1  <= gnt_id ? req1_op1  : req0_op1;
                        cap.op2  <= gnt_id ? req1_op2  : req0_op2;
                        cap.func <= gnt_id ? req1_func : req0_func;
                        cap.id   <= gnt_id;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_sign   <= alu_sign;
                    rsp_ovf    <= alu_ovf;
                    rsp0_valid <= !cap.id;
                    rsp1_valid <= cap.id;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    last_gnt <= cap.id;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port list, one per line: name  direction  width  meaning.
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high reset
  req0_valid  in  1  requester 0 has an operation pending
  req0_op1  in  8  requester 0 operand 1
  req0_op2  in  8  requester 0 operand 2
  req0_func  in  3  requester 0 function code
  req0_ready  out  1  requester 0 accepted this cycle
  req1_valid, req1_op1, req1_op2, req1_func, req1_ready  --  same as requester 0, for requester 1
  rsp0_valid  out  1  one-cycle pulse: result for requester 0 is on the response bus
  rsp1_valid  out  1  one-cycle pulse: result for requester 1 is on the response bus
  rsp_result  out  8  registered ALU result, shared response bus
  rsp_zero  out  1  registered zero flag
  rsp_sign  out  1  registered sign flag
  rsp_ovf  out  1  registered overflow flag
  busy  out  1  high in any state other than IDLE
REQ-003 Function codes SHALL be: ADD=1, SUB=2, AND=3, OR=4, XOR=5; codes 0, 6 and 7 SHALL be legal and produce result 0.

Function
REQ-004 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-005 IDLE with no requester valid: stay in IDLE; both ready outputs low.
REQ-006 IDLE with at least one requester valid: grant exactly one requester and assert only its ready, combinationally in the same cycle; on that edge, capture its op1, op2, func and the grant id, then go to EXEC.
REQ-007 Both requesters valid in IDLE: grant the requester not served last (round-robin). With only one valid, grant that one regardless of history.
REQ-008 ready SHALL be low in EXEC and RESP; a handshake is valid & ready, and operands SHALL NOT be sampled at any other time.
REQ-009 EXEC: drive the ALU from the captured registers; on the edge leaving EXEC, register result, zero, sign and ovf into the rsp_* outputs; go to RESP.
REQ-010 RESP: pulse the rsp valid of the granted requester for exactly one cycle; update the last-grant pointer; return to IDLE.
REQ-011 Latency: rsp valid SHALL rise two cycles after the handshake cycle; peak throughput SHALL be one operation per 3 cycles.
REQ-012 rsp_result and the rsp flags SHALL hold their values until the next EXEC-to-RESP edge.
REQ-013 Flags SHALL pass through from the ALU unmodified: zero = (result == 0); sign = result[7]; ovf as produced by the ALU.
REQ-014 A requester that drops valid before it is granted SHALL lose no state and SHALL cause no side effects.
REQ-015 A requester holding valid high after its handshake SHALL be treated as a new request at the next IDLE.

Reset
REQ-016 Reset SHALL take priority over every other event, including reset asserted mid-operation.
REQ-017 On the reset edge: state = IDLE; all rsp_* = 0; rsp0_valid = rsp1_valid = 0; busy = 0; captured operands = 0; last-grant pointer = 1, so requester 0 wins the first contention.
REQ-018 Reset during EXEC or RESP SHALL drop the transaction; no rsp valid pulse SHALL be issued for it.

Structure
REQ-019 A shared package SHALL hold the function-code constants, the state encoding and the 8-bit data width constant.
REQ-020 The existing combinational ALU SHALL be instantiated as the only sub-module; the arbiter SHALL NOT duplicate any arithmetic.

Verification
REQ-021 req0 ADD 8'h05, 8'h03 -> req0_ready high in the handshake cycle; rsp0_valid two cycles later; rsp_result = 8'h08; zero = 0; sign = 0.
REQ-022 After reset, both valid in the same cycle (req0 SUB 8'h10, 8'h10; req1 OR 8'h0A, 8'h50) -> req0 served first with result 8'h00, zero = 1; req1 served next with result 8'h5A.
REQ-023 Both valid continuously for 12 cycles -> grants alternate 0, 1, 0, 1; ready asserted only in IDLE; one response every 3 cycles.
REQ-024 reset pulsed during EXEC -> next cycle state = IDLE, all outputs 0, no rsp valid pulse for the dropped operation.
REQ-025 XOR 8'hF0, 8'h0F -> result 8'hFF, sign = 1, zero = 0; func = 0 with any operands -> result 8'h00, zero = 1, ovf = 0.
REQ-026 req1 valid for one cycle during RESP, then dropped -> no grant, no response, and the round-robin pointer is unchanged.
